// File: rtl/sa_operand_feeder.sv
// Operand feeder for an N x N systolic array: buffers A/B rows and streams them
// skewed onto the west/north lanes, then waits for the array's result-valid.
module sa_operand_feeder #(
  parameter int N         = 4,
  parameter int WDATA     = 4,
  parameter int CFG_WIDTH = $clog2(N) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic                   load_sel,
  input  logic [$clog2(N)-1:0]   load_idx,
  input  logic [N*WDATA-1:0]     load_data,
  input  logic                   start,
  input  logic [CFG_WIDTH-1:0]   row_cfg_in,
  input  logic [CFG_WIDTH-1:0]   col_cfg_in,
  output logic [N*WDATA-1:0]     matrix_W,
  output logic [N*WDATA-1:0]     matrix_N,
  output logic [CFG_WIDTH-1:0]   row_cfg_out,
  output logic [CFG_WIDTH-1:0]   col_cfg_out,
  input  logic                   sa_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(4 * N) + 1;
  localparam logic [CNT_W-1:0]     LAST_T    = CNT_W'(2 * N - 2);
  localparam logic [CNT_W-1:0]     DRAIN_MAX = CNT_W'(4 * N - 1);
  localparam logic [CFG_WIDTH-1:0] CFG_FULL  = CFG_WIDTH'(N);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WDATA-1:0] buf_a [N][N];
  logic [WDATA-1:0] buf_b [N][N];
  logic [N*WDATA-1:0] w_next, n_next;
  logic start_acc, set_timeout;
  int unsigned t_u;

  function automatic logic [CFG_WIDTH-1:0] clamp_cfg(input logic [CFG_WIDTH-1:0] c);
    return (c == '0 || c > CFG_FULL) ? CFG_FULL : c;
  endfunction

  assign load_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign start_acc  = (state == S_IDLE) && start;

  // Buffers are deliberately outside reset so operands survive an abort.
  always_ff @(posedge clk) begin
    if (load_valid && load_ready) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (load_sel) buf_b[load_idx][IDX_W'(k)] <= load_data[k*WDATA +: WDATA];
        else          buf_a[load_idx][IDX_W'(k)] <= load_data[k*WDATA +: WDATA];
      end
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    set_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FEED;
          cnt_next   = '0;
        end
      end
      S_FEED: begin
        if (cnt == LAST_T) begin
          state_next = S_DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (sa_valid) begin
          state_next = S_DONE;
        end else if (cnt == DRAIN_MAX) begin
          state_next  = S_DONE;
          set_timeout = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Skew: lane i sees element t-i, so the wavefront enters one lane per cycle.
  always_comb begin
    w_next = '0;
    n_next = '0;
    t_u    = 32'(cnt);
    if (state == S_FEED) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (t_u >= i && (t_u - i) < N) begin
          if (i < 32'(row_cfg_out))
            w_next[i*WDATA +: WDATA] = buf_a[IDX_W'(i)][IDX_W'(t_u - i)];
          if (i < 32'(col_cfg_out))
            n_next[i*WDATA +: WDATA] = buf_b[IDX_W'(t_u - i)][IDX_W'(i)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      matrix_W    <= '0;
      matrix_N    <= '0;
      timeout_err <= 1'b0;
      row_cfg_out <= CFG_FULL;
      col_cfg_out <= CFG_FULL;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      matrix_W <= w_next;
      matrix_N <= n_next;
      if (start_acc) begin
        row_cfg_out <= clamp_cfg(row_cfg_in);
        col_cfg_out <= clamp_cfg(col_cfg_in);
        timeout_err <= 1'b0;
      end else if (set_timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sa_operand_feeder.sv
// Directed + randomized bench for sa_operand_feeder against a matrix-level
// reference of the skewed operand streams.
module tb_sa_operand_feeder;

  localparam int NN = 4;
  localparam int WD = 4;
  localparam int CW = $clog2(NN) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic              load_sel = 1'b0;
  logic [1:0]        load_idx = '0;
  logic [NN*WD-1:0]  load_data = '0;
  logic              start = 1'b0;
  logic [CW-1:0]     row_cfg_in = '0;
  logic [CW-1:0]     col_cfg_in = '0;
  logic [NN*WD-1:0]  mat_w, mat_n;
  logic [CW-1:0]     row_cfg_out, col_cfg_out;
  logic              sa_valid = 1'b0;
  logic              busy, done, timeout_err;

  int total = 0;
  int bad   = 0;
  int ma [NN][NN];
  int mb [NN][NN];

  sa_operand_feeder #(.N(NN), .WDATA(WD), .CFG_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_sel(load_sel), .load_idx(load_idx), .load_data(load_data),
    .start(start), .row_cfg_in(row_cfg_in), .col_cfg_in(col_cfg_in),
    .matrix_W(mat_w), .matrix_N(mat_n), .row_cfg_out(row_cfg_out),
    .col_cfg_out(col_cfg_out), .sa_valid(sa_valid), .busy(busy),
    .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_cfg(input int c);
    return (c == 0 || c > NN) ? NN : c;
  endfunction

  // West lane i at time t carries A[i][t-i]; north lane j carries B[t-j][j].
  function automatic logic [31:0] exp_w(input int t, input int rc);
    logic [31:0] v = '0;
    for (int i = 0; i < NN; i++)
      if (t - i >= 0 && t - i < NN && i < rc) v[i*WD +: WD] = WD'(ma[i][t-i]);
    return v;
  endfunction

  function automatic logic [31:0] exp_n(input int t, input int cc);
    logic [31:0] v = '0;
    for (int j = 0; j < NN; j++)
      if (t - j >= 0 && t - j < NN && j < cc) v[j*WD +: WD] = WD'(mb[t-j][j]);
    return v;
  endfunction

  task automatic load_row(input logic sel, input int idx, input int e0, input int e1,
                          input int e2, input int e3);
    int e [NN];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    load_valid = 1'b1; load_sel = sel; load_idx = 2'(idx);
    for (int k = 0; k < NN; k++) begin
      load_data[k*WD +: WD] = WD'(e[k]);
      if (sel) mb[idx][k] = e[k]; else ma[idx][k] = e[k];
    end
  endtask

  // Caller may leave a load pending; it is committed alongside the start.
  task automatic run_feed(input int rc, input int cc, input int sa_delay, input bit hold_load);
    int er, ec, n;
    er = eff_cfg(rc); ec = eff_cfg(cc);
    row_cfg_in = CW'(rc); col_cfg_in = CW'(cc);
    start = 1'b1;
    tick();
    start = 1'b0; load_valid = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("row_cfg_out", 32'(row_cfg_out), 32'(er));
    chk("col_cfg_out", 32'(col_cfg_out), 32'(ec));
    chk("timeout_cleared", 32'(timeout_err), 0);
    if (hold_load) begin
      load_valid = 1'b1; load_sel = 1'b0; load_idx = 2'd0; load_data = 16'hFFFF;
    end
    for (int t = 0; t <= 2*NN-2; t++) begin
      if (hold_load) chk("load_ready_feed", 32'(load_ready), 0);
      tick();
      chk($sformatf("W_t%0d", t), 32'(mat_w), exp_w(t, er));
      chk($sformatf("N_t%0d", t), 32'(mat_n), exp_n(t, ec));
    end
    load_valid = 1'b0;
    n = 0;
    sa_valid = (sa_delay == 0);
    while (!done && n < 4*NN + 4) begin
      tick();
      n++;
      sa_valid = (n == sa_delay);
      chk("lanes_zero_drain", 32'({mat_w, mat_n}), 0);
    end
    sa_valid = 1'b0;
    chk("done_seen", 32'(done), 1);
    chk("drain_cycles", n, (sa_delay >= 0) ? sa_delay + 1 : 4*NN);
    chk("timeout_flag", 32'(timeout_err), (sa_delay >= 0) ? 0 : 1);
    tick();
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_after_done", 32'(busy), 0);
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_lanes", 32'({mat_w, mat_n}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_ready", 32'(load_ready), 1);
    chk("rst_cfg", 32'({row_cfg_out, col_cfg_out}), 32'({CW'(NN), CW'(NN)}));

    // Identity A, B rows = {1,2,3,4}.
    for (int r = 0; r < NN; r++) begin
      load_row(1'b0, r, r == 0, r == 1, r == 2, r == 3); tick();
      load_row(1'b1, r, 1, 2, 3, 4); tick();
    end
    load_valid = 1'b0;
    run_feed(4, 4, 3, 1'b0);

    // Partial config and clamp of zero.
    run_feed(2, 3, 1, 1'b0);
    run_feed(0, 4, 0, 1'b0);

    // Timeout, then clear on next start.
    run_feed(4, 4, -1, 1'b0);
    run_feed(4, 4, 2, 1'b0);

    // Loads during feed are blocked; replay shows old data.
    run_feed(4, 4, 1, 1'b1);
    run_feed(4, 4, 1, 1'b0);

    // Load and start in the same IDLE cycle.
    load_row(1'b1, 2, 9, 10, 11, 12);
    run_feed(4, 4, 2, 1'b0);

    // Reset mid-FEED at t=3.
    start = 1'b1; row_cfg_in = CW'(4); col_cfg_in = CW'(4);
    tick();
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("abort_W", 32'(mat_w), exp_w(t, 4));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_lanes", 32'({mat_w, mat_n}), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    run_feed(4, 4, 0, 1'b0);

    // Randomized operands and configs.
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < NN; r++) begin
        load_row(1'b0, r, $urandom_range(15), $urandom_range(15), $urandom_range(15),
                 $urandom_range(15));
        tick();
        load_row(1'b1, r, $urandom_range(15), $urandom_range(15), $urandom_range(15),
                 $urandom_range(15));
        tick();
      end
      load_valid = 1'b0;
      run_feed(int'($urandom_range(5)), int'($urandom_range(5)),
               int'($urandom_range(5)), 1'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sa_operand_feeder.md
SA_OPERAND_FEEDER -- requirements
Module: sa_operand_feeder

Interface
REQ-001 SHALL have parameter N, default 4, meaning array dimension (PEs per row/column).
REQ-002 SHALL have parameter WDATA, default 4, meaning operand element width in bits.
REQ-003 SHALL have parameter CFG_WIDTH, default $clog2(N)+1, meaning width of the row/column active-size configuration.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port load_valid, input, 1, meaning the load word is valid.
REQ-007 SHALL have port load_ready, output, 1, meaning a load is accepted this cycle.
REQ-008 SHALL have port load_sel, input, 1: 0 = A row (west operand), 1 = B row (north operand).
REQ-009 SHALL have port load_idx, input, $clog2(N), meaning the row index (0-based) being written.
REQ-010 SHALL have port load_data, input, N*WDATA, meaning the packed row; element k is bits [k*WDATA +: WDATA].
REQ-011 SHALL have port start, input, 1, meaning a request to begin feeding.
REQ-012 SHALL have ports row_cfg_in and col_cfg_in, input, CFG_WIDTH each, meaning active rows and active columns.
REQ-013 SHALL have port matrix_W, output, N x WDATA (lanes 1..N), meaning the west operand stream to the array.
REQ-014 SHALL have port matrix_N, output, N x WDATA (lanes 1..N), meaning the north operand stream to the array.
REQ-015 SHALL have ports row_cfg_out and col_cfg_out, output, CFG_WIDTH each, meaning the latched configuration driven to the array.
REQ-016 SHALL have port sa_valid, input, 1, meaning the array's result-valid flag.
REQ-017 SHALL have ports busy, done and timeout_err, output, 1 each: busy = not IDLE; done = 1-cycle completion pulse; timeout_err = sticky drain-timeout flag.

Function
REQ-018 SHALL hold two N x N WDATA buffers, A and B; an accepted load (load_valid & load_ready) writes row load_idx of the buffer chosen by load_sel.
REQ-019 SHALL drive load_ready = 1 only in IDLE; loads in any other state are not accepted and the buffers are unchanged.
REQ-020 SHALL implement the states IDLE, FEED, DRAIN and DONE.
REQ-021 SHALL move from IDLE to FEED on start = 1; start outside IDLE is ignored.
REQ-022 SHALL, on a cycle with start = 1 and an accepted load together in IDLE, commit the load first so it is visible to the feed.
REQ-023 SHALL latch row_cfg_in and col_cfg_in on start; a value of 0 or greater than N is clamped to N; the latched values drive row_cfg_out/col_cfg_out until the next start.
REQ-024 SHALL, in FEED, count t from 0 to 2N-2 (2N-1 cycles) and register each lane output so it appears one cycle after the count value.
REQ-025 SHALL drive W lane i (1..N) with A[i-1][t-(i-1)] when 0 <= t-(i-1) <= N-1 and i <= row_cfg, otherwise 0.
REQ-026 SHALL drive N lane j (1..N) with B[t-(j-1)][j-1] when 0 <= t-(j-1) <= N-1 and j <= col_cfg, otherwise 0.
REQ-027 SHALL move from FEED to DRAIN after t = 2N-2; in DRAIN all lanes are driven 0.
REQ-028 SHALL, in DRAIN, move to DONE when sa_valid = 1.
REQ-029 SHALL, in DRAIN, set timeout_err and move to DONE if sa_valid has not arrived after 4N cycles.
REQ-030 SHALL assert done for exactly one cycle in DONE and then return to IDLE.
REQ-031 SHALL clear timeout_err on the next accepted start.
REQ-032 SHALL leave buffer contents unchanged by feeding, so repeated starts replay the same operands.

Reset
REQ-033 SHALL, while rst = 1 at a clock edge, go to IDLE and zero all matrix_W/matrix_N lanes, busy, done, timeout_err and the feed counter; load_ready is 1 after reset.
REQ-034 SHALL set row_cfg_out and col_cfg_out to N on reset.
REQ-035 SHALL NOT clear the operand buffers on reset.
REQ-036 SHALL, when rst is asserted mid-FEED or mid-DRAIN, abort the feed; the next cycle is IDLE with zero lanes and no done pulse.

Verification
REQ-037 Identity test: N=4, A = identity, B rows = {1,2,3,4}, then start -> W lane 1 = 1 at t=0, W lane 4 = 1 at t=6, N lane 2 = 2 at t=1, 7 FEED cycles; sa_valid 3 cycles later -> done pulses once.
REQ-038 Partial config: row_cfg=2, col_cfg=3 -> W lanes 3-4 and N lane 4 stay 0 through the whole feed; row_cfg_in=0 clamps row_cfg_out to 4.
REQ-039 Timeout: sa_valid never asserted -> timeout_err sets 16 cycles into DRAIN with done; the next start clears it.
REQ-040 Load blocking: load_valid held during FEED with new data -> load_ready = 0 and the replayed feed shows the old data; a load and start in the same IDLE cycle -> the new row is fed.
REQ-041 Reset mid-FEED at t=3 -> the next cycle is IDLE with all lanes 0, busy 0 and no done; a following start replays the unchanged buffers.
